// File: rtl/lfsr.sv
// lfsr: free-running maximal-length Fibonacci LFSR (WIDTH 3..8); define LFSR_LOCKUP_GUARD_EN to recover from the all-zero state
module lfsr #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out
);
  localparam logic [7:0] taps = WIDTH == 3 ? 8'h06 :
                                WIDTH == 4 ? 8'h0c :
                                WIDTH == 5 ? 8'h14 :
                                WIDTH == 6 ? 8'h30 :
                                WIDTH == 7 ? 8'h60 : 8'hb8;
  localparam logic [WIDTH-1:0] tap_mask = taps[WIDTH-1:0];
`ifdef LFSR_LOCKUP_GUARD_EN
  localparam logic [WIDTH-1:0] init_val = SEED == '0 ? WIDTH'(1) : SEED;
`else
  localparam logic [WIDTH-1:0] init_val = SEED;
`endif
  if (WIDTH < 3 || WIDTH > 8) begin : g_bad_width
    $error("lfsr: WIDTH must be 3..8");
  end
`ifndef LFSR_LOCKUP_GUARD_EN
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr: SEED must be non-zero");
  end
`endif
  logic [WIDTH-1:0] nxt;
  // shift left, parity of the tapped bits enters at the LSB
  always_comb begin
`ifdef LFSR_LOCKUP_GUARD_EN
    nxt = out == '0 ? init_val : {out[WIDTH-2:0], ^(out & tap_mask)};
`else
    nxt = {out[WIDTH-2:0], ^(out & tap_mask)};
`endif
  end
  // state register, reset loads the seed immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= init_val;
    else out <= nxt;
  end
endmodule

// File: tb/tb_lfsr.sv
// tb_lfsr: directed and randomized checks of lfsr against a polynomial reference model
module tb_lfsr;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] out;
  logic [7:0] out8;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr dut (.clk(clk), .reset(reset), .out(out));
  lfsr #(.WIDTH(8), .SEED(8'h01)) dut8 (.clk(clk), .reset(reset), .out(out8));

  function automatic logic [7:0] model_next(input int w, input logic [7:0] s);
    logic [7:0] t;
    case (w)
      3: t = 8'h06;
      4: t = 8'h0c;
      5: t = 8'h14;
      6: t = 8'h30;
      7: t = 8'h60;
      default: t = 8'hb8;
    endcase
    return 8'(((32'(s) << 1) | 32'(^(s & t))) & ((32'd1 << w) - 1));
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [3:0] seq [15];
    logic [3:0] m;
    logic [7:0] m8;
    logic [15:0] seen;
    logic [255:0] seen8;
    int k;
    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hd, 4'ha,
            4'h5, 4'hb, 4'h7, 4'hf, 4'he, 4'hc, 4'h8};
    reset = 1'b1;
    #1;
    check("reset_async", 8'(out), 8'h01);
    check("reset_async8", out8, 8'h01);
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_hold", 8'(out), 8'h01);
    end
    @(negedge clk) reset = 1'b0;
    m = 4'h1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      m = 4'(model_next(4, 8'(m)));
      check("seq_list", 8'(out), 8'(seq[(i + 1) % 15]));
      check("seq_model", 8'(out), 8'(m));
    end
    @(negedge clk) reset = 1'b1;
    #1 check("period_reset", 8'(out), 8'h01);
    @(negedge clk) reset = 1'b0;
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("nonzero", 8'(out == 4'h0), 8'h00);
      check("distinct", 8'(seen[out]), 8'h00);
      seen[out] = 1'b1;
    end
    check("wrap_seed", 8'(out), 8'h01);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("at_1101", 8'(out), 8'h0d);
    #2 reset = 1'b1;
    #1 check("async_mid", 8'(out), 8'h01);
    check("async_mid8", out8, 8'h01);
    repeat (6) begin
      @(negedge clk) reset = 1'b0;
      k = int'($urandom_range(1, 40));
      m = 4'h1;
      repeat (k) begin
        @(posedge clk); #1;
        m = 4'(model_next(4, 8'(m)));
        check("rand_run", 8'(out), 8'(m));
      end
      #($urandom_range(1, 3)) reset = 1'b1;
      #1 check("rand_reset", 8'(out), 8'h01);
    end
    @(negedge clk) reset = 1'b0;
    seen8 = '0;
    m8 = 8'h01;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk); #1;
      m8 = model_next(8, m8);
      check("w8_model", out8, m8);
      check("w8_distinct", 8'(seen8[out8]), 8'h00);
      seen8[out8] = 1'b1;
    end
    check("w8_wrap", out8, 8'h01);
    check("w8_zero_unseen", 8'(seen8[0]), 8'h00);
    @(negedge clk);
    force dut.out = 4'h0;
    #1 release dut.out;
    #1 check("zero_forced", 8'(out), 8'h00);
    @(posedge clk); #1;
`ifdef LFSR_LOCKUP_GUARD_EN
    check("lockup_recover", 8'(out), 8'h01);
    @(posedge clk); #1;
    check("lockup_next", 8'(out), 8'h02);
`else
    check("zero_sticky", 8'(out), 8'h00);
    @(posedge clk); #1;
    check("zero_sticky2", 8'(out), 8'h00);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
